// File: rtl/mult8_pkg.sv
// Shared types and constants for the 8x8 sequential multiplier.
package mult8_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned PP_W   = 2 * NIB_W;
  localparam int unsigned SH_W   = 4;

  // Left shift applied to each partial product before accumulation.
  localparam int unsigned SH_PP0 = 0;
  localparam int unsigned SH_PP1 = 4;
  localparam int unsigned SH_PP2 = 4;
  localparam int unsigned SH_PP3 = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP0  = 3'd1,
    PP1  = 3'd2,
    PP2  = 3'd3,
    PP3  = 3'd4,
    DONE = 3'd5
  } state_e;

  // Shift amount for the partial product produced in a given state.
  function automatic logic [SH_W-1:0] pp_shift(input state_e s);
    logic [SH_W-1:0] sh;
    sh = SH_W'(SH_PP0);
    case (s)
      PP1:     sh = SH_W'(SH_PP1);
      PP2:     sh = SH_W'(SH_PP2);
      PP3:     sh = SH_W'(SH_PP3);
      default: sh = SH_W'(SH_PP0);
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mult8x8_sequencer_multiplier_4x4.sv
// Combinational 4x4 unsigned multiplier core shared by all partial products.
// Ports: a, b - 4-bit operands; p - 8-bit product.
module Multiplier_4x4
  import mult8_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic [PP_W-1:0]  p
);

  // Widen before multiplying so the full 8-bit product is kept.
  assign p = PP_W'(a) * PP_W'(b);

endmodule

// File: rtl/mult8x8_sequencer.sv
// Sequential 8x8 unsigned multiplier: accepts a/b over a valid/ready
// handshake, accumulates four nibble partial products through one shared
// 4x4 core, and returns the 16-bit product over a second handshake.
// Ports:
//   clk, rst_n                - clock, async active-low reset
//   start_valid, start_ready  - operand handshake (a, b sampled on accept)
//   abort                     - synchronous cancel of the operation in flight
//   result_valid, result_ready, product - result handshake
//   busy                      - high whenever not idle
module mult8x8_sequencer
  import mult8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic              abort,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  state_e             state, state_d;
  logic [OP_W-1:0]    op_a, op_a_d;
  logic [OP_W-1:0]    op_b, op_b_d;
  logic [PROD_W-1:0]  acc, acc_d;

  logic [NIB_W-1:0]   core_a, core_b;
  logic [PP_W-1:0]    core_p;
  logic [PROD_W-1:0]  addend;
  logic               accept;

  // Nibble select for the shared core, driven from the latched operands.
  always_comb begin
    core_a = op_a[NIB_W-1:0];
    core_b = op_b[NIB_W-1:0];
    case (state)
      PP1: begin
        core_a = op_a[OP_W-1:NIB_W];
        core_b = op_b[NIB_W-1:0];
      end
      PP2: begin
        core_a = op_a[NIB_W-1:0];
        core_b = op_b[OP_W-1:NIB_W];
      end
      PP3: begin
        core_a = op_a[OP_W-1:NIB_W];
        core_b = op_b[OP_W-1:NIB_W];
      end
      default: begin
        core_a = op_a[NIB_W-1:0];
        core_b = op_b[NIB_W-1:0];
      end
    endcase
  end

  Multiplier_4x4 u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  assign addend = PROD_W'(core_p) << pp_shift(state);

  // Ready is combinational on result_ready so a hand-off and a new accept
  // can share one edge.
  assign start_ready = (state == IDLE) | ((state == DONE) & result_ready);
  assign accept      = start_valid & start_ready & ~abort;

  // Next-state, operand and accumulator logic.
  always_comb begin
    state_d = state;
    op_a_d  = op_a;
    op_b_d  = op_b;
    acc_d   = acc;

    case (state)
      IDLE: if (accept) state_d = PP0;
      PP0: begin
        acc_d   = acc + addend;
        state_d = PP1;
      end
      PP1: begin
        acc_d   = acc + addend;
        state_d = PP2;
      end
      PP2: begin
        acc_d   = acc + addend;
        state_d = PP3;
      end
      PP3: begin
        acc_d   = acc + addend;
        state_d = DONE;
      end
      DONE: begin
        if (accept)            state_d = PP0;
        else if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      op_a_d = a;
      op_b_d = b;
      acc_d  = '0;
    end

    // Abort wins over accept and hand-off; no effect while idle.
    if (abort && (state != IDLE)) begin
      state_d = IDLE;
      acc_d   = '0;
    end
  end

  // State, operand and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
    end else begin
      state <= state_d;
      op_a  <= op_a_d;
      op_b  <= op_b_d;
      acc   <= acc_d;
    end
  end

  // Status outputs are pure decodes of the state register.
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign product      = (state == DONE) ? acc : '0;

endmodule

// File: tb/tb_mult8x8_sequencer.sv
// Directed self-checking bench for mult8x8_sequencer.
module tb_mult8x8_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        abort;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] product;
  logic        busy;

  int checks;
  int errors;

  mult8x8_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .abort        (abort),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .product      (product),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".start_ready"},  16'(start_ready),  16'h1);
    chk({tag, ".result_valid"}, 16'(result_valid), 16'h0);
    chk({tag, ".product"},      product,           16'h0000);
    chk({tag, ".busy"},         16'(busy),         16'h0);
  endtask

  // Accept one pair, verify 4-edge latency and product, then hand off.
  task automatic do_mult(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [15:0] exp);
    int n;
    a = ia; b = ib; start_valid = 1'b1; result_ready = 1'b1;
    step();
    start_valid = 1'b0;
    chk({tag, ".busy_after_accept"}, 16'(busy), 16'h1);
    n = 0;
    while (!result_valid && n < 12) begin
      step();
      n++;
    end
    chk({tag, ".latency"}, 16'(n), 16'd4);
    chk({tag, ".product"}, product, exp);
    step();
    chk({tag, ".valid_after_handoff"}, 16'(result_valid), 16'h0);
    chk({tag, ".busy_after_handoff"},  16'(busy),         16'h0);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; start_valid = 1'b0; a = '0; b = '0; abort = 1'b0; result_ready = 1'b0;
    #1;
    chk_idle("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic product with exact busy/latency window.
    a = 8'h12; b = 8'h34; start_valid = 1'b1; result_ready = 1'b0;
    step();
    start_valid = 1'b0;
    chk("t1.start_ready_pp0", 16'(start_ready), 16'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t1.busy_pp", 16'(busy), 16'h1);
      chk("t1.valid_pp", 16'(result_valid), 16'h0);
      step();
    end
    chk("t1.busy_pp3", 16'(busy), 16'h1);
    step();
    chk("t1.valid_done", 16'(result_valid), 16'h1);
    chk("t1.product", product, 16'h03A8);
    result_ready = 1'b1;
    step();
    chk("t1.busy_end", 16'(busy), 16'h0);
    chk("t1.product_idle", product, 16'h0000);

    do_mult("max",  8'hFF, 8'hFF, 16'hFE01);
    do_mult("zero", 8'h00, 8'hA7, 16'h0000);

    // Backpressure in DONE.
    a = 8'hA5; b = 8'h3C; start_valid = 1'b1; result_ready = 1'b0;
    step();
    start_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 3; i++) begin
      chk("bp.valid",       16'(result_valid), 16'h1);
      chk("bp.product",     product,           16'h26AC);
      chk("bp.start_ready", 16'(start_ready),  16'h0);
      step();
    end
    result_ready = 1'b1;
    #1;
    chk("bp.start_ready_on_ready", 16'(start_ready), 16'h1);
    step();
    chk("bp.valid_after", 16'(result_valid), 16'h0);
    chk("bp.busy_after",  16'(busy),         16'h0);

    // Back-to-back with valid and ready held high.
    a = 8'h0F; b = 8'h0F; start_valid = 1'b1; result_ready = 1'b1;
    step();
    a = 8'h10; b = 8'h10;
    for (int i = 0; i < 4; i++) step();
    chk("b2b.first", product, 16'h00E1);
    step();
    chk("b2b.busy_between",  16'(busy),         16'h1);
    chk("b2b.valid_between", 16'(result_valid), 16'h0);
    start_valid = 1'b0;
    n = 1;
    while (!result_valid && n < 12) begin
      step();
      n++;
    end
    chk("b2b.spacing", 16'(n), 16'd5);
    chk("b2b.second",  product, 16'h0100);
    step();
    chk("b2b.busy_end", 16'(busy), 16'h0);

    // start_valid during PP2 is ignored.
    a = 8'h21; b = 8'h02; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    step();
    a = 8'h77; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    chk("ign.valid",   16'(result_valid), 16'h1);
    chk("ign.product", product,           16'h0042);
    step();
    chk("ign.busy_end", 16'(busy), 16'h0);

    // Abort in PP1.
    a = 8'h12; b = 8'h34; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort");
    for (int i = 0; i < 4; i++) step();
    chk("abort.no_result", 16'(result_valid), 16'h0);

    // Abort in IDLE blocks a same-edge start.
    a = 8'h12; b = 8'h34; abort = 1'b1; start_valid = 1'b1;
    step();
    abort = 1'b0; start_valid = 1'b0;
    chk("abort_idle.busy", 16'(busy), 16'h0);

    // Asynchronous reset in PP2.
    a = 8'h55; b = 8'h55; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    step();
    chk("rst.busy_before", 16'(busy), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    #3;
    rst_n = 1'b1;
    #4;
    do_mult("post_rst", 8'h03, 8'h05, 16'h000F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
